tdc_mc_stamp: RTL
=================

Name: tdc_mc_stamp

Overview:
Multi-channel time-to-digital stamper, the parametrised successor of the single-channel TDC path. Per channel it takes a multiphase thermometer snapshot already synchronised into the pll_clk domain, detects rising edges, and forms coarse+fine raw times. It scales the raw time to picoseconds and buffers the results in a FIFO with a valid/ready output.
Two modes: absolute timestamp, or interval from a channel-0 start.

Parameters:
CH_NUM, 4, number of stop/timestamp channels (>=1)
PHASES, 16, fine bins per clock (power of 2, >=2)
CRS_W, 24, coarse counter width
SCALE, 400, ps per fine bin (constant multiplier)
FIFO_DEPTH, 16, output FIFO entries (power of 2)
Derived: FN_W=$clog2(PHASES), RAW_W=CRS_W+FN_W, OUT_W=RAW_W+$clog2(SCALE+1), CH_W=max(1,$clog2(CH_NUM))

Ports:
pll_clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
sig_therm  in  CH_NUM*PHASES  per-channel snapshot; bit k = input sampled at phase k (k=0 earliest); channel c at [c*PHASES +: PHASES]
arm  in  1  1 = accept edges; 0 = ignore new edges (in-flight events still drain)
mode  in  1  0 = absolute; 1 = interval (channel 0 is start)
rdy  in  1  consumer ready
out_time  out  OUT_W  scaled time, ps
out_ch  out  CH_W  originating channel
dval  out  1  out_time/out_ch valid; transfer when dval&rdy
lost_cnt  out  8  saturating count of dropped events

Behaviour:
- Reset: synchronous, clears coarse, prev snapshots, holding regs, RR pointer, start, FIFO and lost_cnt. Outputs dval=0, out_time=0, out_ch=0, lost_cnt=0. Asserting rst mid-operation discards all in-flight events.
- Coarse: free-running CRS_W counter, 0 in the first cycle after rst deasserts; wraps modulo 2^CRS_W.
- Edge: channel c fires when prev_snapshot[PHASES-1]==0 and cur[PHASES-1]==1 and arm==1. fine = index of lowest set bit of cur. raw = {coarse, fine}.
- Stage 1 (cycle N+1): the event is captured into a per-channel holding reg. If that holding reg is still occupied, the new event is dropped and lost_cnt increments.
- Stage 2 (N+2): a round-robin arbiter picks one occupied holding reg and frees it. The pointer moves to winner+1 mod CH_NUM.
- Mode 1 routing in stage 2:
  - A channel-0 winner stores raw as start, sets start_vld and emits nothing.
  - A channel c>0 winner with start_vld=0 is discarded silently; lost_cnt does not change.
  - Otherwise the value is (raw - start) mod 2^RAW_W. Start persists until the next channel-0 event.
- Mode 0: value = raw; channel 0 is an ordinary channel.
- Stage 3 (N+3): registered value*SCALE (unsigned, OUT_W) with channel tag.
- FIFO write at N+3. If the FIFO is full, the event is dropped and lost_cnt increments. There is no backpressure into the pipeline.
- Output: registered FIFO head. For an isolated event into an empty FIFO, dval rises at N+4.
- dval/out_* stay stable until dval&rdy. A pop and a write in the same cycle are allowed when the FIFO is full (the write succeeds).
- lost_cnt saturates at 255. Simultaneous drops in one cycle add their total, saturating.
- A mode change takes effect for events arbitrated from the next cycle on. Switching to mode 0 clears start_vld.

Optional Feature:
TDC_OFFSET_CAL_EN: adds ports cal_wr (1), cal_ch (CH_W) and cal_ofs (signed 8). Writing cal_wr loads a per-channel signed bin offset (reset 0).
Stage 2 subtracts the offset from raw mod 2^RAW_W before mode handling. In mode 1 this applies to both start and stop.
Without the macro, the ports and registers are absent and the offset is effectively 0.

Decomposition:
tdc_pkg: RAW/CH widths as localparam functions, typedef tdc_evt_t {ch, raw}, function lowest_set_idx(therm).
Sub-module tdc_evt_fifo: synchronous FIFO with full/empty, registered show-ahead output, parametrised width and depth.
Edge detect, holding regs, arbiter and scaler live in the top module.

Test Plan:
- Ch1 snapshot 16'hFFC0 at coarse=10, prev MSB 0, mode 0, rdy=1 -> 4 cycles later dval=1, out_ch=1, out_time=(10*16+6)*400=66400.
- Mode 1: ch0 16'hFFFF at coarse 5, ch2 16'hFFF8 at coarse 7 -> one output, out_ch=2, out_time=(115-80)*400=14000; ch0 produces no output.
- Ch0..3 edge in the same cycle, mode 0, rdy=1 -> four dval beats on consecutive cycles, out_ch 0,1,2,3, all with identical raw.
- rdy=0, 20 single-channel events spaced 2 cycles apart -> FIFO holds the first 16 in order and lost_cnt=4; raising rdy drains exactly 16.
- CRS_W=8, mode 1: start at coarse 250 fine 0, stop ch1 at coarse 4 (after wrap) fine 0 -> out_time=(260-250)*16*400=64000.
- Mode 1, ch3 edge with no prior start -> no dval, lost_cnt=0. Then rst pulsed during pending events -> dval=0 and nothing emitted afterwards.

Source files
------------

// File: rtl/tdc_pkg.sv
// tdc_pkg: shared widths, mode encoding, event record and thermometer decode
// for the tdc_mc_stamp multi-channel time stamper.
package tdc_pkg;

    // Event record fields are sized for the largest supported configuration.
    // Narrower instances zero-extend into them and slice back out.
    localparam int unsigned EVT_CH_W  = 8;
    localparam int unsigned EVT_RAW_W = 48;
    localparam int unsigned THERM_MAX = 256;

    typedef enum logic {
        MODE_ABS      = 1'b0,
        MODE_INTERVAL = 1'b1
    } tdc_mode_e;

    typedef struct packed {
        logic [EVT_CH_W-1:0]  ch;
        logic [EVT_RAW_W-1:0] raw;
    } tdc_evt_t;

    function automatic int fn_w(input int phases);
        return $clog2(phases);
    endfunction

    function automatic int raw_w(input int crs_w, input int phases);
        return crs_w + $clog2(phases);
    endfunction

    function automatic int out_w(input int crs_w, input int phases, input int scale);
        return raw_w(crs_w, phases) + $clog2(scale + 1);
    endfunction

    function automatic int ch_w(input int ch_num);
        return (ch_num > 1) ? $clog2(ch_num) : 1;
    endfunction

    // Index of the lowest set bit (earliest phase at which the input was high).
    function automatic logic [7:0] lowest_set_idx(input logic [THERM_MAX-1:0] therm);
        logic [7:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < THERM_MAX; i++) begin
            if (therm[i] && !found) begin
                idx   = 8'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tdc_evt_fifo.sv
// tdc_evt_fifo: synchronous FIFO with a registered show-ahead head.
// The head register always holds the oldest stored entry, so the full
// DEPTH entries are usable and rd_data_o/rd_vld_o come straight from flops.
module tdc_evt_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_vld_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             head_vld_q, head_vld_d;
    logic             do_wr, do_rd;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign rd_data_o = head_q;
    assign rd_vld_o  = head_vld_q;

    // Pointer/count bookkeeping and next head selection (bypass when the
    // entry being written becomes the new head in the same cycle).
    always_comb begin
        do_rd    = rd_en_i && head_vld_q;
        do_wr    = wr_en_i && (!full_o || do_rd);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (do_rd) rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        if (do_wr) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        count_d    = count_q + CW'(do_wr) - CW'(do_rd);
        head_vld_d = (count_d != '0);
        if (!head_vld_d)
            head_d = '0;
        else if (do_wr && (wr_ptr_q == rd_ptr_d))
            head_d = wr_data_i;
        else
            head_d = mem_q[rd_ptr_d];
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // Control state and the registered head.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
        end
    end

endmodule

// File: rtl/tdc_mc_stamp.sv
// tdc_mc_stamp: multi-channel TDC stamper. Edge detect -> per-channel hold
// -> round-robin arbiter / mode routing -> scaler -> output FIFO.
// Optional macro TDC_OFFSET_CAL_EN adds cal_wr/cal_ch/cal_ofs per-channel
// signed bin offsets applied before mode handling.
module tdc_mc_stamp
    import tdc_pkg::*;
#(
    parameter  int unsigned CH_NUM     = 4,
    parameter  int unsigned PHASES     = 16,
    parameter  int unsigned CRS_W      = 24,
    parameter  int unsigned SCALE      = 400,
    parameter  int unsigned FIFO_DEPTH = 16,
    localparam int unsigned FN_W       = fn_w(PHASES),
    localparam int unsigned RAW_W      = raw_w(CRS_W, PHASES),
    localparam int unsigned OUT_W      = out_w(CRS_W, PHASES, SCALE),
    localparam int unsigned CH_W       = ch_w(CH_NUM)
) (
    input  logic                     pll_clk,
    input  logic                     rst,
    input  logic [CH_NUM*PHASES-1:0] sig_therm,
    input  logic                     arm,
    input  logic                     mode,
    input  logic                     rdy,
    output logic [OUT_W-1:0]         out_time,
    output logic [CH_W-1:0]          out_ch,
    output logic                     dval,
    output logic [7:0]               lost_cnt
`ifdef TDC_OFFSET_CAL_EN
   ,input  logic                     cal_wr,
    input  logic [CH_W-1:0]          cal_ch,
    input  logic [7:0]               cal_ofs
`endif
);

    logic [CRS_W-1:0] coarse_q;
    logic [CH_NUM-1:0] prev_q;
    logic [CH_NUM-1:0] edge_c;
    logic [RAW_W-1:0]  raw_c [CH_NUM];

    tdc_evt_t          hold_q [CH_NUM];
    tdc_evt_t          hold_d [CH_NUM];
    logic [CH_NUM-1:0] hold_vld_q, hold_vld_d;
    logic [15:0]       drop1;

    logic              grant_vld;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   ptr_q, ptr_d;

    tdc_mode_e         mode_q;
    logic [RAW_W-1:0]  start_q, start_d;
    logic              start_vld_q, start_vld_d;
    logic [RAW_W-1:0]  ofs_raw, raw_adj;
    tdc_evt_t          evt_g;

    logic              s2_vld_q, s2_vld_d;
    logic [RAW_W-1:0]  s2_val_q, s2_val_d;
    logic [CH_W-1:0]   s2_ch_q, s2_ch_d;
    logic              s3_vld_q;
    logic [OUT_W-1:0]  s3_time_q;
    logic [CH_W-1:0]   s3_ch_q;

    logic              fifo_full, fifo_empty, drop3;
    logic [7:0]        lost_q;
    logic [15:0]       lost_sum;

    // Edge detection and raw {coarse, fine} formation per channel.
    always_comb begin
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            edge_c[c] = arm && !prev_q[c] && sig_therm[c*PHASES + PHASES - 1];
            raw_c[c]  = {coarse_q, FN_W'(lowest_set_idx(THERM_MAX'(sig_therm[c*PHASES +: PHASES])))};
        end
    end

    // Round-robin search starting at the pointer.
    always_comb begin
        int unsigned j;
        j         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            j = (32'(ptr_q) + i) % CH_NUM;
            if (!grant_vld && hold_vld_q[CH_W'(j)]) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'(j);
            end
        end
        ptr_d = ptr_q;
        if (grant_vld)
            ptr_d = (grant_idx == CH_W'(CH_NUM - 1)) ? '0 : grant_idx + CH_W'(1);
    end

    // Hold capture; a slot freed by this cycle's grant may be refilled.
    always_comb begin
        drop1 = '0;
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            hold_vld_d[c] = hold_vld_q[c] && !(grant_vld && (grant_idx == CH_W'(c)));
            hold_d[c]     = hold_q[c];
            if (edge_c[c]) begin
                if (hold_vld_d[c]) begin
                    drop1 = drop1 + 16'd1;
                end else begin
                    hold_vld_d[c] = 1'b1;
                    hold_d[c].ch  = EVT_CH_W'(c);
                    hold_d[c].raw = EVT_RAW_W'(raw_c[c]);
                end
            end
        end
    end

`ifdef TDC_OFFSET_CAL_EN
    logic signed [7:0] cal_q [CH_NUM];

    // Per-channel signed bin offsets loaded through the calibration port.
    always_ff @(posedge pll_clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < CH_NUM; c++) cal_q[c] <= '0;
        end else if (cal_wr && (32'(cal_ch) < CH_NUM)) begin
            cal_q[cal_ch] <= signed'(cal_ofs);
        end
    end

    assign ofs_raw = RAW_W'(cal_q[grant_idx]);
`else
    assign ofs_raw = '0;
`endif

    // Mode routing of the granted event: start capture, interval or absolute.
    always_comb begin
        evt_g       = hold_q[grant_idx];
        raw_adj     = evt_g.raw[RAW_W-1:0] - ofs_raw;
        s2_vld_d    = 1'b0;
        s2_val_d    = raw_adj;
        s2_ch_d     = evt_g.ch[CH_W-1:0];
        start_d     = start_q;
        start_vld_d = start_vld_q && (mode_q == MODE_INTERVAL);
        if (grant_vld) begin
            if (mode_q == MODE_ABS) begin
                s2_vld_d = 1'b1;
            end else if (grant_idx == '0) begin
                start_d     = raw_adj;
                start_vld_d = 1'b1;
            end else if (start_vld_q) begin
                s2_vld_d = 1'b1;
                s2_val_d = raw_adj - start_q;
            end
        end
    end

    assign drop3    = s3_vld_q && fifo_full && !(dval && rdy);
    assign lost_sum = 16'(lost_q) + drop1 + 16'(drop3);

    // Pipeline, arbitration and bookkeeping state.
    always_ff @(posedge pll_clk) begin
        if (rst) begin
            coarse_q    <= '0;
            prev_q      <= '0;
            hold_vld_q  <= '0;
            for (int unsigned c = 0; c < CH_NUM; c++) hold_q[c] <= '0;
            ptr_q       <= '0;
            mode_q      <= MODE_ABS;
            start_q     <= '0;
            start_vld_q <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_val_q    <= '0;
            s2_ch_q     <= '0;
            s3_vld_q    <= 1'b0;
            s3_time_q   <= '0;
            s3_ch_q     <= '0;
            lost_q      <= '0;
        end else begin
            coarse_q    <= coarse_q + CRS_W'(1);
            for (int unsigned c = 0; c < CH_NUM; c++) begin
                prev_q[c] <= sig_therm[c*PHASES + PHASES - 1];
                hold_q[c] <= hold_d[c];
            end
            hold_vld_q  <= hold_vld_d;
            ptr_q       <= ptr_d;
            mode_q      <= tdc_mode_e'(mode);
            start_q     <= start_d;
            start_vld_q <= start_vld_d;
            s2_vld_q    <= s2_vld_d;
            s2_val_q    <= s2_val_d;
            s2_ch_q     <= s2_ch_d;
            s3_vld_q    <= s2_vld_q;
            s3_time_q   <= OUT_W'(s2_val_q) * OUT_W'(SCALE);
            s3_ch_q     <= s2_ch_q;
            lost_q      <= (lost_sum > 16'd255) ? 8'd255 : lost_sum[7:0];
        end
    end

    tdc_evt_fifo #(
        .WIDTH (OUT_W + CH_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (pll_clk),
        .rst_i     (rst),
        .wr_en_i   (s3_vld_q),
        .wr_data_i ({s3_time_q, s3_ch_q}),
        .rd_en_i   (rdy),
        .rd_data_o ({out_time, out_ch}),
        .rd_vld_o  (dval),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign lost_cnt = lost_q;

endmodule
